dbg_display_ctrl: RTL and testbench

//  Parametrised prototyping debug front-end that sits between the board clock and the MIPS core.
//  - Generates the core's advance strobe: free-run tick or debounced single-step button.
//  - Snapshots PC plus one of NCH probe channels after each advance.
//  - Scans the snapshot onto an NDIG-digit multiplexed 7-seg display.
//  - Clock enable only; no derived clocks.

---
 rtl/dbg_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dbg_display_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_display_ctrl.sv
// Debug front-end: core advance strobe (free-run or debounced step), PC/probe snapshot, 7-seg scan.
// Optional DBG_STEPCNT_EN adds a step_cnt output that ch_sel==NCH can display.
module dbg_display_ctrl #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int DB_CNT   = 500_000,
  parameter int NCH      = 8,
  parameter int DW       = 32,
  parameter int NDIG     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pb,
  input  logic                     mode_run,
  input  logic [$clog2(NCH+1)-1:0] ch_sel,
  input  logic [1:0]               win_sel,
  input  logic [DW-1:0]            pc,
  input  logic [NCH*DW-1:0]        probe_bus,
  output logic                     cpu_en,
  output logic [NDIG-1:0]          an,
  output logic [7:0]               sseg
`ifdef DBG_STEPCNT_EN
  ,
  output logic [DW-1:0]            step_cnt
`endif
);
  localparam int H    = NDIG / 2;
  localparam int FW   = 4 * H;
  localparam int CW   = $clog2(NCH + 1);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW  = $clog2(DB_CNT + 1);
  localparam int DIGW = $clog2(NDIG);
  localparam int EW   = (DW > 4 * FW) ? DW : 4 * FW;
  localparam int PW   = (DW > FW + 2) ? DW : FW + 2;

  logic            pb_s1, pb_s2, pb_db, pb_db_q, step_req;
  logic [DBW-1:0]  db_cnt;
  logic            mode_q, mode_chg;
  logic [DIVW-1:0] div;
  logic [CW-1:0]   ch_q;
  logic [1:0]      win_q;
  logic            load_q, sel_chg;
  logic [2*FW-1:0] snap;
  logic [DW-1:0]   chan;
  logic [EW-1:0]   chan_ext;
  logic [PW-1:0]   pc_ext;
  logic [SCW-1:0]  sc;
  logic [DIGW-1:0] dig;
  logic            unused_pc;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0; 4'h1: seg7 = 8'hF9; 4'h2: seg7 = 8'hA4; 4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99; 4'h5: seg7 = 8'h92; 4'h6: seg7 = 8'h82; 4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80; 4'h9: seg7 = 8'h90; 4'hA: seg7 = 8'h88; 4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6; 4'hD: seg7 = 8'hA1; 4'hE: seg7 = 8'h86; default: seg7 = 8'h8E;
    endcase
  endfunction

  // pb_db only moves after DB_CNT consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_s1   <= 1'b0;
      pb_s2   <= 1'b0;
      pb_db   <= 1'b0;
      pb_db_q <= 1'b0;
      db_cnt  <= '0;
    end else begin
      pb_s1   <= pb;
      pb_s2   <= pb_s1;
      pb_db_q <= pb_db;
      if (pb_s2 == pb_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CNT - 1)) begin
        pb_db  <= pb_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign step_req = pb_db & ~pb_db_q;
  assign mode_chg = mode_run != mode_q;

  // cpu_en is registered, so in run mode it is set one count early to land on div==CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      div    <= '0;
      cpu_en <= 1'b0;
    end else begin
      mode_q <= mode_run;
      if (mode_chg) begin
        div    <= '0;
        cpu_en <= 1'b0;
      end else if (mode_q) begin
        div    <= (div == DIVW'(CLK_DIV - 1)) ? '0 : div + 1'b1;
        cpu_en <= (div == DIVW'(CLK_DIV - 2));
      end else begin
        div    <= '0;
        cpu_en <= step_req;
      end
    end
  end

`ifdef DBG_STEPCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_cnt <= '0;
    else if (cpu_en) step_cnt <= step_cnt + 1'b1;
  end
`endif

  always_comb begin
    chan = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CW'(k)) chan = probe_bus[k*DW +: DW];
    end
`ifdef DBG_STEPCNT_EN
    if (ch_q == CW'(NCH)) chan = step_cnt;
`endif
  end

  assign chan_ext  = EW'(chan);
  assign pc_ext    = PW'(pc);
  assign unused_pc = ^{pc_ext[PW-1:FW+2], pc_ext[1:0]};
  assign sel_chg   = (ch_sel != ch_q) || (win_sel != win_q);

  // Snapshot layout: upper H digits = word address, lower H digits = channel window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q   <= '0;
      win_q  <= '0;
      load_q <= 1'b0;
      snap   <= '0;
    end else begin
      ch_q   <= ch_sel;
      win_q  <= win_sel;
      load_q <= cpu_en | sel_chg;
      if (load_q) snap <= {pc_ext[FW+1:2], chan_ext[win_q*FW +: FW]};
    end
  end

  // an and sseg update together so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc   <= '0;
      dig  <= '0;
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      if (sc == SCW'(SCAN_DIV - 1)) begin
        sc  <= '0;
        dig <= (dig == DIGW'(NDIG - 1)) ? '0 : dig + 1'b1;
      end else begin
        sc <= sc + 1'b1;
      end
      an   <= ~(NDIG'(1) << dig);
      sseg <= seg7(snap[dig*4 +: 4]);
    end
  end
endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Directed bench for dbg_display_ctrl with small dividers (CLK_DIV=4, SCAN_DIV=2, DB_CNT=3).
module tb_dbg_display_ctrl;
  localparam int CLK_DIV = 4, SCAN_DIV = 2, DB_CNT = 3, NCH = 2, DW = 32, NDIG = 4;

  logic        clk = 1'b0;
  logic        reset, pb, mode_run;
  logic [1:0]  ch_sel, win_sel;
  logic [31:0] pc;
  logic [63:0] probe_bus;
  logic        cpu_en;
  logic [3:0]  an;
  logic [7:0]  sseg;
`ifdef DBG_STEPCNT_EN
  logic [31:0] step_cnt;
`endif

  int n_checks = 0, n_fail = 0, total_en = 0;
  logic [7:0] seen [4];
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  dbg_display_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV), .DB_CNT(DB_CNT),
                     .NCH(NCH), .DW(DW), .NDIG(NDIG)) dut (
    .clk(clk), .reset(reset), .pb(pb), .mode_run(mode_run), .ch_sel(ch_sel),
    .win_sel(win_sel), .pc(pc), .probe_bus(probe_bus), .cpu_en(cpu_en),
    .an(an), .sseg(sseg)
`ifdef DBG_STEPCNT_EN
    , .step_cnt(step_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Independent count of strobes since the last reset.
  always @(negedge clk) begin
    if (reset) total_en = 0;
    else if (cpu_en) total_en = total_en + 1;
  end

  task automatic count_en(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (cpu_en) c++;
    end
  endtask

  task automatic press(input int n, output int c);
    int c2;
    pb = 1'b1;
    count_en(n, c);
    pb = 1'b0;
    count_en(20, c2);
    c += c2;
  endtask

  // Captures the pattern shown for each digit over two full scan periods.
  task automatic collect();
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    repeat (6) @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      case (an)
        4'hE: seen[0] = sseg;
        4'hD: seen[1] = sseg;
        4'hB: seen[2] = sseg;
        4'h7: seen[3] = sseg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pb = 1'b0; mode_run = 1'b0; ch_sel = 2'd0; win_sel = 2'd0;
    pc = '0; probe_bus = '0;
    repeat (5) @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected %h", an, 4'hF); end
    n_checks++; if (sseg !== 8'hFF) begin n_fail++; $display("FAIL reset_sseg: got %h expected %h", sseg, 8'hFF); end
    n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (an !== 4'hE) begin n_fail++; $display("FAIL first_digit_an: got %h expected %h", an, 4'hE); end
    n_checks++; if (sseg !== 8'hC0) begin n_fail++; $display("FAIL first_digit_sseg: got %h expected %h", sseg, 8'hC0); end
  endtask

  task automatic test_run();
    int c = 0, last = -1, bad = 0, c_off;
    mode_run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        if (last >= 0 && i - last != CLK_DIV) bad++;
        last = i;
        c++;
      end
    end
    n_checks++; if (c != 25) begin n_fail++; $display("FAIL run_pulses: got %0d expected 25", c); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL run_spacing: got %0d bad gaps expected 0", bad); end
    mode_run = 1'b0;
    count_en(20, c_off);
    n_checks++; if (c_off != 0) begin n_fail++; $display("FAIL step_idle: got %0d pulses expected 0", c_off); end
  endtask

  task automatic test_step();
    int c, c1;
    press(2, c);
    n_checks++; if (c != 0) begin n_fail++; $display("FAIL short_press: got %0d pulses expected 0", c); end
    press(10, c);
    n_checks++; if (c != 1) begin n_fail++; $display("FAIL long_press: got %0d pulses expected 1", c); end
    c = 0;
    for (int i = 0; i < 4; i++) begin
      pb = (i % 2 == 0);
      count_en(1, c1);
      c += c1;
    end
    press(10, c1);
    c += c1;
    n_checks++; if (c != 1) begin n_fail++; $display("FAIL bounce_press: got %0d pulses expected 1", c); end
  endtask

  task automatic test_snapshot();
    int c;
    pc = 32'h10; probe_bus = {32'hDEADBEEF, 32'h12345678}; ch_sel = 2'd1; win_sel = 2'd0;
    press(6, c);
    n_checks++; if (c != 1) begin n_fail++; $display("FAIL snap_step: got %0d pulses expected 1", c); end
    collect();
    n_checks++; if (seen[0] !== 8'h8E) begin n_fail++; $display("FAIL snap_dig0: got %h expected %h", seen[0], 8'h8E); end
    n_checks++; if (seen[1] !== 8'h86) begin n_fail++; $display("FAIL snap_dig1: got %h expected %h", seen[1], 8'h86); end
    n_checks++; if (seen[2] !== 8'h99) begin n_fail++; $display("FAIL snap_dig2: got %h expected %h", seen[2], 8'h99); end
    n_checks++; if (seen[3] !== 8'hC0) begin n_fail++; $display("FAIL snap_dig3: got %h expected %h", seen[3], 8'hC0); end
    pc = 32'h20;
    collect();
    n_checks++; if (seen[2] !== 8'h99) begin n_fail++; $display("FAIL snap_hold: got %h expected %h", seen[2], 8'h99); end
    press(6, c);
    collect();
    n_checks++; if (seen[2] !== 8'h80) begin n_fail++; $display("FAIL snap_pc_update: got %h expected %h", seen[2], 8'h80); end
  endtask

  task automatic test_window();
    win_sel = 2'd1;
    collect();
    n_checks++; if (seen[0] !== 8'h86) begin n_fail++; $display("FAIL win1_dig0: got %h expected %h", seen[0], 8'h86); end
    n_checks++; if (seen[1] !== 8'h83) begin n_fail++; $display("FAIL win1_dig1: got %h expected %h", seen[1], 8'h83); end
    n_checks++; if (seen[2] !== 8'h80) begin n_fail++; $display("FAIL win1_upper: got %h expected %h", seen[2], 8'h80); end
    win_sel = 2'd2;
    collect();
    n_checks++; if (seen[0] !== 8'hA1) begin n_fail++; $display("FAIL win2_dig0: got %h expected %h", seen[0], 8'hA1); end
    n_checks++; if (seen[1] !== 8'h88) begin n_fail++; $display("FAIL win2_dig1: got %h expected %h", seen[1], 8'h88); end
    win_sel = 2'd3;
    collect();
    n_checks++; if (seen[0] !== 8'h86) begin n_fail++; $display("FAIL win3_dig0: got %h expected %h", seen[0], 8'h86); end
    n_checks++; if (seen[1] !== 8'hA1) begin n_fail++; $display("FAIL win3_dig1: got %h expected %h", seen[1], 8'hA1); end
  endtask

  task automatic test_channel_select();
    logic [7:0] cnt8;
    win_sel = 2'd0; ch_sel = 2'd0;
    collect();
    n_checks++; if (seen[0] !== 8'h80) begin n_fail++; $display("FAIL ch0_dig0: got %h expected %h", seen[0], 8'h80); end
    n_checks++; if (seen[1] !== 8'hF8) begin n_fail++; $display("FAIL ch0_dig1: got %h expected %h", seen[1], 8'hF8); end
    ch_sel = 2'd3;
    collect();
    n_checks++; if (seen[0] !== 8'hC0) begin n_fail++; $display("FAIL ch3_dig0: got %h expected %h", seen[0], 8'hC0); end
    n_checks++; if (seen[1] !== 8'hC0) begin n_fail++; $display("FAIL ch3_dig1: got %h expected %h", seen[1], 8'hC0); end
    ch_sel = 2'd2;
    collect();
`ifdef DBG_STEPCNT_EN
    cnt8 = total_en[7:0];
    n_checks++; if (step_cnt !== 32'(total_en)) begin n_fail++; $display("FAIL step_cnt: got %0d expected %0d", step_cnt, total_en); end
`else
    cnt8 = 8'h00;
`endif
    n_checks++; if (seen[0] !== seg_tbl[cnt8[3:0]]) begin n_fail++; $display("FAIL ch2_dig0: got %h expected %h", seen[0], seg_tbl[cnt8[3:0]]); end
    n_checks++; if (seen[1] !== seg_tbl[cnt8[7:4]]) begin n_fail++; $display("FAIL ch2_dig1: got %h expected %h", seen[1], seg_tbl[cnt8[7:4]]); end
  endtask

  task automatic test_reset_mid_step();
    int c;
    pb = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_reset_an: got %h expected %h", an, 4'hF); end
    reset = 1'b0;
    count_en(4, c);
    n_checks++; if (c != 0) begin n_fail++; $display("FAIL mid_reset_early: got %0d pulses expected 0", c); end
    count_en(10, c);
    n_checks++; if (c != 1) begin n_fail++; $display("FAIL mid_reset_fresh: got %0d pulses expected 1", c); end
    pb = 1'b0;
    count_en(20, c);
    n_checks++; if (c != 0) begin n_fail++; $display("FAIL mid_reset_release: got %0d pulses expected 0", c); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_snapshot();
    test_window();
    test_channel_select();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
